gshare_predictor: RTL and testbench
===================================

// Module: gshare_predictor
// PURPOSE
//  Dynamic gshare branch predictor feeding the IF-stage next-PC mux and receiving resolved outcomes from EX.
//  - IF side: PC bits are XORed with a global history register (GHR) to index a table of 2-bit saturating counters (PHT).
//  - EX side: the resolved outcome trains the PHT, shifts the GHR and updates mispredict/branch statistics.
//  - The IF-time index travels down the pipeline with the branch (IF/ID, ID/EX) and returns as ex_index.
// PARAMETERS
//  INDEX_BITS  6      PHT index width; PHT has 2**INDEX_BITS entries.
//  GHR_BITS    6      global history length; legal range 1..INDEX_BITS.
//  CNT_INIT    2'b01  counter value loaded at reset (weakly not-taken).
//  STAT_W      32     width of the statistics counters.
// PORTS
//  clk               in   1           rising-edge clock.
//  reset             in   1           synchronous, active-high reset.
//  if_pc             in   64          PC of the instruction in IF.
//  if_is_branch      in   1           IF instruction is a conditional branch.
//  prediction        out  1           predict taken; combinational from IF inputs.
//  pred_index        out  INDEX_BITS  index used for this lookup; pipelined to EX.
//  ex_branch         in   1           a branch is resolving in EX this cycle.
//  ex_outcome        in   1           resolved direction: 1 = taken.
//  ex_prediction     in   1           prediction that was made for the EX branch.
//  ex_index          in   INDEX_BITS  pred_index carried with the EX branch.
//  mispredict        out  1           ex_branch & (ex_prediction ^ ex_outcome); combinational.
//  ghr               out  GHR_BITS    current global history; bit 0 = newest outcome.
//  branch_count      out  STAT_W      number of resolved branches.
//  mispredict_count  out  STAT_W      number of resolved mispredicts.
// BEHAVIOUR
//  - Index: pred_index = if_pc[INDEX_BITS+1:2] ^ {{(INDEX_BITS-GHR_BITS){1'b0}}, ghr}.
//  - Prediction: prediction = if_is_branch & pht[pred_index][1]. Zero-cycle latency, asynchronous table read.
//  - Update: at each posedge with ex_branch=1 and reset=0:
//      - pht[ex_index] saturating +1 if ex_outcome, else -1 (11 stays 11, 00 stays 00).
//      - ghr <= {ghr[GHR_BITS-2:0], ex_outcome}; for GHR_BITS=1, ghr <= ex_outcome.
//      - branch_count += 1; mispredict_count += mispredict.
//  - ex_branch=0: PHT, GHR and statistics hold.
//  - Read/write collision (pred_index == ex_index in the same cycle): the lookup returns the pre-update value.
//    The new value is visible from the next cycle.
//  - GHR is non-speculative: it holds resolved outcomes only. Flushed wrong-path branches never reach EX and never train.
//  - Statistics counters saturate at all-ones and do not wrap.
//  - Reset (synchronous):
//      - All PHT entries = CNT_INIT; ghr = 0; both statistics counters = 0.
//      - Reset takes priority over a coincident ex_branch update; that update is discarded.
//      - Reset mid-run clears all history in one cycle.
//      - Combinational outputs follow their inputs during reset; prediction reflects the table contents before the reset edge.
//  - ex_index is not checked against pred_index history; EX must return exactly the index issued in IF.
// STRUCTURE
//  - Package bp_pkg:
//      - counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
//      - function sat2_next(cnt, taken), returning the saturated next counter value.
//      - typedef for the 2-bit counter.
//  - Sub-module pht_array:
//      - parameters INDEX_BITS, CNT_INIT.
//      - one asynchronous read port; one synchronous write port (we, waddr, taken).
//      - holds the counter array and applies sat2_next on write.
//  - Top level holds: GHR register, index XOR, mispredict logic, statistics counters.
//  - Elaboration-time check: GHR_BITS must lie in 1..INDEX_BITS.
// TESTING
//  1. Reset, then if_pc=0x40, if_is_branch=1 -> pred_index=0x10, prediction=0, ghr=0, both counts=0.
//  2. Three taken resolves at ex_index=5 -> pht[5] follows 01->10->11->11.
//     ghr=6'b000111, branch_count=3, mispredict_count=2 (ex_prediction=0 on the first two).
//  3. ex_branch=1, ex_prediction=1, ex_outcome=0 -> mispredict=1 in the same cycle, mispredict_count +1 at the next edge.
//     Same inputs with ex_branch=0 -> mispredict=0, no state change.
//  4. Collision: pht[3]=01, lookup index 3 while a taken update to 3 -> prediction=0 this cycle, prediction=1 next cycle.
//  5. Train pht[7] to 11 and ghr to 0x2A, assert reset together with ex_branch=1 ->
//     pht[7]=01, ghr=0, counts=0; the coincident update is not applied.
//  6. Preload branch_count=all-ones, resolve one more branch -> count stays all-ones.
//     ghr with GHR_BITS=4 shifts 4'b1010 -> 4'b0101 on ex_outcome=1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_pkg;

  typedef logic [1:0] cnt2T;

  localparam cnt2T SNT = 2'b00;
  localparam cnt2T WNT = 2'b01;
  localparam cnt2T WT  = 2'b10;
  localparam cnt2T ST  = 2'b11;

  // Two-bit saturating step: count up on taken, down on not-taken.
  function automatic cnt2T sat2_next(input cnt2T cnt, input logic taken);
    cnt2T nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'b01;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_predictor_pht_array.sv
// Pattern history table of 2-bit saturating counters.
// Latency: read is combinational; a write lands at the clock edge.
// Backpressure: none; one read and one write are accepted every cycle.
module pht_array
  import bp_pkg::*;
#(
  parameter int   INDEX_BITS = 6,
  parameter cnt2T CNT_INIT   = WNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] raddr,
  output cnt2T                  rdata,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  logic                  taken
);

  localparam int Entries = 2 ** INDEX_BITS;

  cnt2T table_q [Entries];

  // Read returns the stored value, so a same-cycle write is seen only next cycle.
  assign rdata = table_q[raddr];

  // Whole-table reset, otherwise train the written entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Entries; i++) table_q[i] <= CNT_INIT;
    end else if (we) begin
      table_q[waddr] <= sat2_next(table_q[waddr], taken);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes the PHT; EX trains it.
// Latency: prediction and mispredict are combinational; training takes effect next cycle.
// Backpressure: none; a lookup and an update are accepted every cycle.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int   INDEX_BITS = 6,
  parameter int   GHR_BITS   = 6,
  parameter cnt2T CNT_INIT   = WNT,
  parameter int   STAT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           if_pc,
  input  logic                  if_is_branch,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  ex_branch,
  input  logic                  ex_outcome,
  input  logic                  ex_prediction,
  input  logic [INDEX_BITS-1:0] ex_index,
  output logic                  mispredict,
  output logic [GHR_BITS-1:0]   ghr,
  output logic [STAT_W-1:0]     branch_count,
  output logic [STAT_W-1:0]     mispredict_count
);

  if (GHR_BITS < 1 || GHR_BITS > INDEX_BITS) begin : gBadGhr
    $error("gshare_predictor: GHR_BITS must lie in 1..INDEX_BITS");
  end

  cnt2T                  lookupCnt;
  logic [INDEX_BITS-1:0] ghrExt;
  logic [GHR_BITS-1:0]   ghrNext;

  assign ghrExt     = INDEX_BITS'(ghr);
  assign pred_index = if_pc[INDEX_BITS+1:2] ^ ghrExt;
  assign prediction = if_is_branch & lookupCnt[1];
  assign mispredict = ex_branch & (ex_prediction ^ ex_outcome);

  // Newest resolved outcome enters at bit 0.
  if (GHR_BITS == 1) begin : gGhr1
    assign ghrNext = ex_outcome;
  end else begin : gGhrN
    assign ghrNext = {ghr[GHR_BITS-2:0], ex_outcome};
  end

  pht_array #(
    .INDEX_BITS(INDEX_BITS),
    .CNT_INIT  (CNT_INIT)
  ) uPht (
    .clk  (clk),
    .reset(reset),
    .raddr(pred_index),
    .rdata(lookupCnt),
    .we   (ex_branch),
    .waddr(ex_index),
    .taken(ex_outcome)
  );

  // History and statistics advance only on resolved branches; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr              <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (ex_branch) begin
      ghr <= ghrNext;
      if (branch_count != '1) branch_count <= branch_count + 1'b1;
      if (mispredict && (mispredict_count != '1)) mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with a queue-based scoreboard.
// Latency: checks combinational outputs and post-edge state on the falling edge.
// Backpressure: n/a.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ifPc;
  logic        ifIsBranch;
  logic        prediction;
  logic [5:0]  predIndex;
  logic        exBranch, exOutcome, exPrediction;
  logic [5:0]  exIndex;
  logic        mispredict;
  logic [5:0]  ghr;
  logic [31:0] branchCount, mispredictCount;

  // Second instance: short history and narrow counters for saturation checks.
  logic        reset2;
  logic        ex2Branch, ex2Outcome;
  logic        prediction2, mispredict2;
  logic [5:0]  predIndex2;
  logic [3:0]  ghr2;
  logic [3:0]  branchCount2, mispredictCount2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } expT;

  expT sb[$];

  always #5 clk = ~clk;

  gshare_predictor dut (
    .clk(clk), .reset(reset), .if_pc(ifPc), .if_is_branch(ifIsBranch),
    .prediction(prediction), .pred_index(predIndex),
    .ex_branch(exBranch), .ex_outcome(exOutcome), .ex_prediction(exPrediction),
    .ex_index(exIndex), .mispredict(mispredict), .ghr(ghr),
    .branch_count(branchCount), .mispredict_count(mispredictCount)
  );

  gshare_predictor #(.INDEX_BITS(6), .GHR_BITS(4), .CNT_INIT(2'b01), .STAT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .if_pc(64'h0), .if_is_branch(1'b0),
    .prediction(prediction2), .pred_index(predIndex2),
    .ex_branch(ex2Branch), .ex_outcome(ex2Outcome), .ex_prediction(1'b0),
    .ex_index(6'd0), .mispredict(mispredict2), .ghr(ghr2),
    .branch_count(branchCount2), .mispredict_count(mispredictCount2)
  );

  function automatic logic [63:0] pick(input int sel);
    case (sel)
      0: return 64'(prediction);
      1: return 64'(predIndex);
      2: return 64'(mispredict);
      3: return 64'(ghr);
      4: return 64'(branchCount);
      5: return 64'(mispredictCount);
      6: return 64'(ghr2);
      7: return 64'(branchCount2);
      default: return 64'(mispredictCount2);
    endcase
  endfunction

  // Monitor: drain the scoreboard against the settled DUT outputs.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      expT e;
      logic [63:0] act;
      e = sb.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic expectVal(input string name, input int sel, input logic [63:0] v);
    expT e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic isBr, input logic br,
                       input logic outc, input logic pred, input logic [5:0] idx);
    ifPc         = pc;
    ifIsBranch   = isBr;
    exBranch     = br;
    exOutcome    = outc;
    exPrediction = pred;
    exIndex      = idx;
  endtask

  task automatic expState(input string tag, input logic [5:0] g, input logic [31:0] bc,
                          input logic [31:0] mc);
    expectVal({tag, "_ghr"}, 3, 64'(g));
    expectVal({tag, "_bcnt"}, 4, 64'(bc));
    expectVal({tag, "_mcnt"}, 5, 64'(mc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    ex2Branch = 1'b0;
    ex2Outcome = 1'b0;
    drive(64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state and index formation
    drive(64'h40, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    expectVal("rst_index", 1, 64'h10);
    expectVal("rst_pred", 0, 64'd0);
    expState("rst", 6'd0, 32'd0, 32'd0);
    cyc();

    // Three taken resolves at index 5 while looking index 5 up
    drive(64'h14, 1'b1, 1'b1, 1'b1, 1'b0, 6'd5);
    expectVal("t2a_pred", 0, 64'd0);
    expectVal("t2a_misp", 2, 64'd1);
    cyc();
    drive(64'h10, 1'b1, 1'b1, 1'b1, 1'b0, 6'd5);
    expectVal("t2b_index", 1, 64'd5);
    expectVal("t2b_pred", 0, 64'd1);
    expState("t2b", 6'd1, 32'd1, 32'd1);
    cyc();
    drive(64'h18, 1'b1, 1'b1, 1'b1, 1'b1, 6'd5);
    expectVal("t2c_pred", 0, 64'd1);
    expectVal("t2c_misp", 2, 64'd0);
    expState("t2c", 6'd3, 32'd2, 32'd2);
    cyc();

    // Not-taken mispredict, then the same inputs with ex_branch low
    drive(64'h08, 1'b1, 1'b1, 1'b0, 1'b1, 6'd5);
    expectVal("t3a_pred", 0, 64'd1);
    expectVal("t3a_misp", 2, 64'd1);
    expState("t3a", 6'd7, 32'd3, 32'd2);
    cyc();
    drive(64'h2C, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5);
    expectVal("t3b_misp", 2, 64'd0);
    expectVal("t3b_sat_pred", 0, 64'd1);
    expState("t3b", 6'd14, 32'd4, 32'd3);
    cyc();

    // Collision on index 3: old value this cycle, new value next cycle
    drive(64'h34, 1'b1, 1'b1, 1'b1, 1'b0, 6'd3);
    expState("t4a_hold", 6'd14, 32'd4, 32'd3);
    expectVal("t4a_index", 1, 64'd3);
    expectVal("t4a_pred", 0, 64'd0);
    cyc();
    drive(64'h78, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    expectVal("t4b_index", 1, 64'd3);
    expectVal("t4b_pred", 0, 64'd1);
    expState("t4b", 6'd29, 32'd5, 32'd4);
    cyc();
    drive(64'h78, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    expectVal("t4c_nobranch_pred", 0, 64'd0);
    cyc();

    // Train pht[7] to strongly taken and ghr to 0x2A
    for (int i = 0; i < 6; i++) begin
      drive(64'h0, 1'b0, 1'b1, (i % 2 == 0), 1'b0, (i % 2 == 0) ? 6'd7 : 6'd9);
      cyc();
    end
    // Reset coincident with an update; lookup sees pre-reset table
    drive(64'hB4, 1'b1, 1'b1, 1'b1, 1'b0, 6'd7);
    reset = 1'b1;
    expState("t5_pre", 6'h2A, 32'd11, 32'd7);
    expectVal("t5_pre_pred", 0, 64'd1);
    expectVal("t5_rst_misp", 2, 64'd1);
    cyc();
    reset = 1'b0;
    drive(64'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    expState("t5_post", 6'd0, 32'd0, 32'd0);
    expectVal("t5_post_index", 1, 64'd7);
    expectVal("t5_post_pred", 0, 64'd0);
    cyc();
    drive(64'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 6'd7);
    cyc();
    drive(64'h18, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    expectVal("t5_retrain_pred", 0, 64'd1);
    expState("t5_retrain", 6'd1, 32'd1, 32'd1);
    cyc();

    // Narrow instance: counter saturation and 4-bit history shift
    reset2 = 1'b0;
    expectVal("t6_bcnt_start", 7, 64'd0);
    for (int i = 0; i < 17; i++) begin
      ex2Branch  = 1'b1;
      ex2Outcome = (i == 13) || (i == 15);
      if (i == 15) expectVal("t6_bcnt_15", 7, 64'd15);
      cyc();
    end
    ex2Branch = 1'b0;
    expectVal("t6_ghr_1010", 6, 64'hA);
    expectVal("t6_bcnt_sat", 7, 64'd15);
    expectVal("t6_mcnt", 8, 64'd2);
    cyc();
    ex2Branch  = 1'b1;
    ex2Outcome = 1'b1;
    cyc();
    ex2Branch = 1'b0;
    expectVal("t6_ghr_0101", 6, 64'h5);
    expectVal("t6_bcnt_hold", 7, 64'd15);
    expectVal("t6_mcnt_inc", 8, 64'd3);
    cyc();

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
